chime_sequencer: RTL and testbench
==================================

# chime_sequencer

Consumes the BCD time outputs of the 12-hour clock and plays the Westminster quarters: 4, 8, 12 or 16 notes at :15, :30, :45 and :00. On the hour it then rings one bell strike per hour, 1–12. Each note and strike goes out over a valid/ready channel to the tone generator. The block sits between the clock and the audio path and shares the clock's 1 Hz enable as its pacing tick.

## Interface
- NOTE_GAP, 1: tick pulses to wait after a note inside a phrase.
- PHRASE_GAP, 2: tick pulses to wait after the last note of a phrase, and before the first strike.
- STRIKE_GAP, 3: tick pulses to wait after each hour strike.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- tick  input  1  single-cycle pacing enable, same signal as the clock's ena.
- hh  input  8  BCD hour, 0x01–0x12.
- mm  input  8  BCD minute.
- ss  input  8  BCD second.
- out_ready  input  1  downstream accepts the current code.
- out_valid  output  1  out_code is valid.
- out_code  output  3  0=B3, 1=E4, 2=F#4, 3=G#4, 4=hour bell.
- busy  output  1  a sequence is in progress.
- missed  output  1  one-cycle pulse when a trigger is dropped.

## Operation
- Note ROM: 20 entries (5 changes × 4 notes), indexed 0..19. Entries:
  - change 1: 3,2,1,0
  - change 2: 1,3,2,0
  - change 3: 1,2,3,1
  - change 4: 3,1,2,0
  - change 5: 0,2,3,1
- Trigger:
  - {mm,ss} is registered every cycle.
  - A trigger fires when {mm,ss} changes to 15:00, 30:00, 45:00 or 00:00.
  - The first cycle after reset deasserts only loads the history register and never triggers.
- Sequence chosen at trigger (start index, length); the index pointer wraps modulo 20:
  - :15 → (0, 4)
  - :30 → (4, 8)
  - :45 → (12, 12)
  - :00 → (4, 16), followed by strikes.
- Strike count is latched from hh at trigger: BCD 01–12 maps to 1–12; any other value maps to 12.
- FSM states: IDLE, NOTE, NOTE_GAP, STRIKE, STRIKE_GAP.
  - IDLE → NOTE on trigger.
  - NOTE: hold out_valid=1 with the ROM code until out_ready. Then go to NOTE_GAP, loading NOTE_GAP ticks, or PHRASE_GAP ticks when the sent note was the 4th of a phrase.
  - NOTE_GAP → NOTE when the gap expires and notes remain.
  - NOTE_GAP → STRIKE on gap expiry when the notes are done and it is the hour.
  - NOTE_GAP → IDLE on gap expiry when the notes are done and it is a quarter.
  - STRIKE: out_code=4, hold until out_ready, then go to STRIKE_GAP loading STRIKE_GAP ticks.
  - STRIKE_GAP → STRIKE when the gap expires and strikes remain; otherwise → IDLE.
- Gap counters decrement only on tick. A gap of G waits exactly G tick pulses after the transfer cycle. A tick arriving in the transfer cycle itself is not counted.
- busy=1 in every state except IDLE.
- A trigger while busy is dropped, missed pulses for one cycle, and the running sequence is unaffected.
- A trigger coincident with the final gap expiry is also dropped, with missed pulsed.

## Timing
- Reset values: out_valid=0, out_code=0, busy=0, missed=0, FSM=IDLE, history register cleared.
- Reset asserted mid-sequence clears all of the above immediately, without waiting for clk. Nothing resumes after release.
- Latency: {mm,ss} changes in cycle N, the trigger is detected in cycle N+1, and out_valid=1 in cycle N+2.
- Handshake:
  - A transfer occurs on a cycle where out_valid && out_ready are both high.
  - out_code is stable while out_valid=1 && out_ready=0.
  - out_valid drops the cycle after a transfer and never rises during a gap.
- missed is registered and asserts the cycle after the dropped trigger is detected.

## Structure
- A shared package holds the note ROM contents, the code constants (B3, E4, FS4, GS4, BELL), the quarter start/length constants, and the FSM state encoding.
- One sub-module, chime_trigger_detect, holds the {mm,ss} history, primed flag, quarter decode and hh-to-count conversion. Its outputs are a one-cycle trigger plus the latched start, length, hour flag and strike count.

## Test plan
- 12:14:59 → 12:15:00, out_ready=1, NOTE_GAP=1 → codes 3,2,1,0, one transfer per tick. Then busy falls after 2 ticks, with no code 4.
- 03:59:59 → 04:00:00 → 16 codes 1,3,2,0,1,2,3,1,3,1,2,0,0,2,3,1, then four code-4 transfers spaced 3 ticks apart, then busy=0.
- 06:44:59 → 06:45:00 → 12 codes: ROM 12..19 then 0..3, i.e. 3,1,2,0,0,2,3,1,3,2,1,0.
- out_ready held 0 for 5 cycles during the first note of :30 → out_valid=1 and out_code=1 stable throughout; the note is transferred once when ready rises.
- During the :00 sequence, force {mm,ss} from 14:59 to 15:00 → missed is a 1-cycle pulse; the hour sequence completes with all notes and strikes intact.
- Reset pulled low mid-strike at 11:00 → out_valid, busy and missed are 0 immediately. After release with the time static, there is no output.

Source files
------------

// File: rtl/chime_sequencer_pkg.sv
// Shared constants for the Westminster chime sequencer: note codes, change ROM,
// quarter sequence selection and FSM encoding.
package chime_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StNote,
      StNoteGap,
      StStrike,
      StStrikeGap
   } state_e;

   localparam logic [2:0] CodeB3   = 3'd0;
   localparam logic [2:0] CodeE4   = 3'd1;
   localparam logic [2:0] CodeFs4  = 3'd2;
   localparam logic [2:0] CodeGs4  = 3'd3;
   localparam logic [2:0] CodeBell = 3'd4;

   localparam int unsigned RomDepth = 20;

   localparam logic [4:0] StartQ15 = 5'd0;
   localparam logic [4:0] LenQ15   = 5'd4;
   localparam logic [4:0] StartQ30 = 5'd4;
   localparam logic [4:0] LenQ30   = 5'd8;
   localparam logic [4:0] StartQ45 = 5'd12;
   localparam logic [4:0] LenQ45   = 5'd12;
   localparam logic [4:0] StartQ00 = 5'd4;
   localparam logic [4:0] LenQ00   = 5'd16;

   // Five changes of four notes each, played back to back with wrap at 20.
   function automatic logic [2:0] note_rom(input logic [4:0] idx);
      logic [2:0] code;
      case (idx)
         5'd0:    code = CodeGs4;
         5'd1:    code = CodeFs4;
         5'd2:    code = CodeE4;
         5'd3:    code = CodeB3;
         5'd4:    code = CodeE4;
         5'd5:    code = CodeGs4;
         5'd6:    code = CodeFs4;
         5'd7:    code = CodeB3;
         5'd8:    code = CodeE4;
         5'd9:    code = CodeFs4;
         5'd10:   code = CodeGs4;
         5'd11:   code = CodeE4;
         5'd12:   code = CodeGs4;
         5'd13:   code = CodeE4;
         5'd14:   code = CodeFs4;
         5'd15:   code = CodeB3;
         5'd16:   code = CodeB3;
         5'd17:   code = CodeFs4;
         5'd18:   code = CodeGs4;
         5'd19:   code = CodeE4;
         default: code = CodeB3;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/chime_trigger_detect.sv
// Watches {mm,ss} for a change onto a quarter hour and latches the sequence
// parameters (start, length, hour flag, strike count) alongside a one-cycle trigger.
module chime_trigger_detect
   import chime_sequencer_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] hh_i,
   input  logic [7:0] mm_i,
   input  logic [7:0] ss_i,
   output logic       trig_o,
   output logic [4:0] start_o,
   output logic [4:0] len_o,
   output logic       hour_o,
   output logic [3:0] strikes_o
);

   logic [15:0] hist_q;
   logic        primed_q;
   logic        trig_q;
   logic        trig_d;
   logic [4:0]  start_q, start_sel;
   logic [4:0]  len_q, len_sel;
   logic        hour_q, hour_sel;
   logic [3:0]  strikes_q, strikes_sel;
   logic        quarter;

   always_comb begin
      quarter   = 1'b0;
      hour_sel  = 1'b0;
      start_sel = StartQ15;
      len_sel   = LenQ15;
      if (ss_i == 8'h00) begin
         case (mm_i)
            8'h15: begin quarter = 1'b1; start_sel = StartQ15; len_sel = LenQ15; end
            8'h30: begin quarter = 1'b1; start_sel = StartQ30; len_sel = LenQ30; end
            8'h45: begin quarter = 1'b1; start_sel = StartQ45; len_sel = LenQ45; end
            8'h00: begin
               quarter   = 1'b1;
               hour_sel  = 1'b1;
               start_sel = StartQ00;
               len_sel   = LenQ00;
            end
            default: ;
         endcase
      end
   end

   // Out-of-range BCD hours ring the full twelve.
   always_comb begin
      strikes_sel = 4'd12;
      if (hh_i[7:4] == 4'd0 && hh_i[3:0] >= 4'd1 && hh_i[3:0] <= 4'd9) begin
         strikes_sel = hh_i[3:0];
      end else if (hh_i[7:4] == 4'd1 && hh_i[3:0] <= 4'd2) begin
         strikes_sel = 4'd10 + hh_i[3:0];
      end
   end

   assign trig_d = primed_q && quarter && ({mm_i, ss_i} != hist_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hist_q    <= '0;
         primed_q  <= 1'b0;
         trig_q    <= 1'b0;
         start_q   <= '0;
         len_q     <= '0;
         hour_q    <= 1'b0;
         strikes_q <= '0;
      end else begin
         hist_q   <= {mm_i, ss_i};
         primed_q <= 1'b1;
         trig_q   <= trig_d;
         if (trig_d) begin
            start_q   <= start_sel;
            len_q     <= len_sel;
            hour_q    <= hour_sel;
            strikes_q <= strikes_sel;
         end
      end
   end

   assign trig_o    = trig_q;
   assign start_o   = start_q;
   assign len_o     = len_q;
   assign hour_o    = hour_q;
   assign strikes_o = strikes_q;

endmodule

// File: rtl/chime_sequencer.sv
// Westminster quarters and hour strikes, paced by the clock's 1 Hz tick and
// delivered one code at a time over a valid/ready channel.
module chime_sequencer
   import chime_sequencer_pkg::*;
#(
   parameter int unsigned NoteGap   = 1,
   parameter int unsigned PhraseGap = 2,
   parameter int unsigned StrikeGap = 3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic [7:0] hh_i,
   input  logic [7:0] mm_i,
   input  logic [7:0] ss_i,
   input  logic       out_ready_i,
   output logic       out_valid_o,
   output logic [2:0] out_code_o,
   output logic       busy_o,
   output logic       missed_o
);

   logic       trig;
   logic [4:0] trig_start, trig_len;
   logic       trig_hour;
   logic [3:0] trig_strikes;

   state_e     state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [4:0] notes_q, notes_d;
   logic [3:0] strikes_q, strikes_d;
   logic       hour_q, hour_d;
   logic [7:0] gap_q, gap_d;
   logic       missed_q, missed_d;
   logic       gap_done;

   chime_trigger_detect u_trigger_detect (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .hh_i      (hh_i),
      .mm_i      (mm_i),
      .ss_i      (ss_i),
      .trig_o    (trig),
      .start_o   (trig_start),
      .len_o     (trig_len),
      .hour_o    (trig_hour),
      .strikes_o (trig_strikes)
   );

   assign gap_done = tick_i && (gap_q == 8'd1);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      notes_d     = notes_q;
      strikes_d   = strikes_q;
      hour_d      = hour_q;
      gap_d       = gap_q;
      out_valid_o = 1'b0;
      out_code_o  = CodeB3;
      busy_o      = (state_q != StIdle);
      // Any trigger outside IDLE is dropped, including one landing on the final expiry.
      missed_d    = trig && (state_q != StIdle);

      if ((state_q == StNoteGap || state_q == StStrikeGap) && tick_i && gap_q != 8'd0) begin
         gap_d = gap_q - 8'd1;
      end

      case (state_q)
         StIdle: begin
            if (trig) begin
               state_d   = StNote;
               idx_d     = trig_start;
               notes_d   = trig_len;
               hour_d    = trig_hour;
               strikes_d = trig_strikes;
            end
         end
         StNote: begin
            out_valid_o = 1'b1;
            out_code_o  = note_rom(idx_q);
            if (out_ready_i) begin
               state_d = StNoteGap;
               notes_d = notes_q - 5'd1;
               idx_d   = (idx_q == 5'(RomDepth - 1)) ? 5'd0 : idx_q + 5'd1;
               gap_d   = (idx_q[1:0] == 2'd3) ? 8'(PhraseGap) : 8'(NoteGap);
            end
         end
         StNoteGap: begin
            if (gap_done) begin
               if (notes_q != 5'd0) begin
                  state_d = StNote;
               end else if (hour_q) begin
                  state_d = StStrike;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StStrike: begin
            out_valid_o = 1'b1;
            out_code_o  = CodeBell;
            if (out_ready_i) begin
               state_d   = StStrikeGap;
               strikes_d = strikes_q - 4'd1;
               gap_d     = 8'(StrikeGap);
            end
         end
         StStrikeGap: begin
            if (gap_done) begin
               state_d = (strikes_q != 4'd0) ? StStrike : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         notes_q   <= '0;
         strikes_q <= '0;
         hour_q    <= 1'b0;
         gap_q     <= '0;
         missed_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         notes_q   <= notes_d;
         strikes_q <= strikes_d;
         hour_q    <= hour_d;
         gap_q     <= gap_d;
         missed_q  <= missed_d;
      end
   end

   assign missed_o = missed_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench: an event-queue model of the chime output is compared with
// the DUT every cycle, plus literal code sequences for the directed scenarios.
module tb_chime_sequencer;

   localparam int NG = 1;
   localparam int PG = 2;
   localparam int SG = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick  = 1'b0;
   logic [7:0] hh    = 8'h12;
   logic [7:0] mm    = 8'h10;
   logic [7:0] ss    = 8'h59;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [2:0] out_code;
   logic       busy;
   logic       missed;

   always #5 clk = ~clk;

   chime_sequencer #(
      .NoteGap   (NG),
      .PhraseGap (PG),
      .StrikeGap (SG)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .tick_i      (tick),
      .hh_i        (hh),
      .mm_i        (mm),
      .ss_i        (ss),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_code_o  (out_code),
      .busy_o      (busy),
      .missed_o    (missed)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   int   rom [20] = '{3, 2, 1, 0, 1, 3, 2, 0, 1, 2, 3, 1, 3, 1, 2, 0, 0, 2, 3, 1};
   int   mq [$];        // codes still to be sent
   int   mg [$];        // tick gap that follows each code
   int   m_wait   = 0;  // ticks still to wait before the next code
   bit   m_trig   = 0;
   bit   m_primed = 0;
   bit   m_missed = 0;
   bit   m_hour   = 0;
   int   m_start, m_len, m_strikes;
   logic [15:0] m_prev = '0;
   bit   was_busy;
   bit   exp_valid;
   int   log_q [$];
   int   exp_q [$];
   int   miss_cnt = 0;

   function automatic int hour_strikes(input logic [7:0] h);
      int hi, lo, v;
      hi = int'(h[7:4]);
      lo = int'(h[3:0]);
      v  = hi * 10 + lo;
      if (hi <= 9 && lo <= 9 && v >= 1 && v <= 12) return v;
      return 12;
   endfunction

   // Returns minute-of-hour for a quarter mark, or -1.
   function automatic int quarter_of(input logic [7:0] m, input logic [7:0] s);
      if (s != 8'h00) return -1;
      case (m)
         8'h00:   return 0;
         8'h15:   return 15;
         8'h30:   return 30;
         8'h45:   return 45;
         default: return -1;
      endcase
   endfunction

   task automatic load_seq();
      for (int i = 0; i < m_len; i++) begin
         mq.push_back(rom[(m_start + i) % 20]);
         mg.push_back(((i % 4) == 3) ? PG : NG);
      end
      if (m_hour) begin
         for (int i = 0; i < m_strikes; i++) begin
            mq.push_back(4);
            mg.push_back(SG);
         end
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         mg.delete();
         m_wait   = 0;
         m_trig   = 0;
         m_primed = 0;
         m_missed = 0;
         m_prev   = '0;
      end else begin
         if (out_valid && out_ready) log_q.push_back(int'(out_code));
         was_busy = (mq.size() > 0) || (m_wait > 0);
         m_missed = m_trig && was_busy;
         if (m_wait == 0 && mq.size() > 0) begin
            if (out_ready) begin
               void'(mq.pop_front());
               m_wait = mg.pop_front();
            end
         end else if (m_wait > 0 && tick) begin
            m_wait--;
         end
         if (m_trig && !was_busy) load_seq();
         m_trig = m_primed && ({mm, ss} != m_prev) && (quarter_of(mm, ss) >= 0);
         if (m_trig) begin
            case (quarter_of(mm, ss))
               15:      begin m_start = 0;  m_len = 4;  end
               30:      begin m_start = 4;  m_len = 8;  end
               45:      begin m_start = 12; m_len = 12; end
               default: begin m_start = 4;  m_len = 16; end
            endcase
            m_hour    = (quarter_of(mm, ss) == 0);
            m_strikes = hour_strikes(hh);
         end
         m_prev   = {mm, ss};
         m_primed = 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_valid", int'(out_valid), 0);
         check("rst_busy", int'(busy), 0);
         check("rst_missed", int'(missed), 0);
      end else begin
         exp_valid = (mq.size() > 0) && (m_wait == 0);
         check("valid", int'(out_valid), int'(exp_valid));
         if (exp_valid) check("code", int'(out_code), mq[0]);
         check("busy", int'(busy), int'((mq.size() > 0) || (m_wait > 0)));
         check("missed", int'(missed), int'(m_missed));
         if (missed) miss_cnt++;
      end
   end

   // ---------------- tick / ready drivers ----------------
   int tick_mode  = 0;  // 0: every 4th cycle, 1: random
   int ready_mode = 1;  // 0: low, 1: high, 2: random
   int cyc = 0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         tick = (tick_mode == 0) ? ((cyc % 4) == 0) : ($urandom_range(0, 2) == 0);
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      @(negedge clk);
      hh = h;
      mm = m;
      ss = s;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k;
      k = 0;
      cycles(3);
      while ((busy || mq.size() > 0 || m_wait > 0 || m_trig) && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) timeout_fail(name);
   endtask

   task automatic check_log(input string name);
      int n;
      check({name, "_len"}, log_q.size(), exp_q.size());
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check(name, log_q[i], exp_q[i]);
   endtask

   function automatic logic [7:0] rand_hh();
      int r;
      r = $urandom_range(0, 13);
      if (r < 9)   return 8'(r + 1);
      if (r < 12)  return 8'h10 + 8'(r - 9);
      if (r == 12) return 8'h00;
      return 8'h13;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- scenarios ----------------
   initial begin
      cycles(2);
      check("reset_valid", int'(out_valid), 0);
      check("reset_code", int'(out_code), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_missed", int'(missed), 0);
      #2 rst_n = 1'b1;
      cycles(4);

      // :15 quarter
      log_q.delete();
      set_time(8'h12, 8'h14, 8'h59);
      cycles(3);
      set_time(8'h12, 8'h15, 8'h00);
      wait_idle("idle_q15", 500);
      exp_q = '{3, 2, 1, 0};
      check_log("seq_q15");

      // 4 o'clock: full phrase set then four strikes
      log_q.delete();
      set_time(8'h03, 8'h59, 8'h59);
      cycles(3);
      set_time(8'h04, 8'h00, 8'h00);
      wait_idle("idle_h04", 2000);
      exp_q = '{1, 3, 2, 0, 1, 2, 3, 1, 3, 1, 2, 0, 0, 2, 3, 1, 4, 4, 4, 4};
      check_log("seq_h04");

      // :45 quarter wraps the ROM pointer
      log_q.delete();
      set_time(8'h06, 8'h44, 8'h59);
      cycles(3);
      set_time(8'h06, 8'h45, 8'h00);
      wait_idle("idle_q45", 1000);
      exp_q = '{3, 1, 2, 0, 0, 2, 3, 1, 3, 2, 1, 0};
      check_log("seq_q45");

      // :30 with downstream stalled on the first note
      log_q.delete();
      ready_mode = 0;
      set_time(8'h12, 8'h29, 8'h59);
      cycles(3);
      set_time(8'h12, 8'h30, 8'h00);
      begin
         int k;
         k = 0;
         while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
         end
         if (k >= 20) timeout_fail("stall_valid");
      end
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", int'(out_valid), 1);
         check("stall_code", int'(out_code), 1);
         @(negedge clk);
      end
      check("stall_no_xfer", log_q.size(), 0);
      ready_mode = 1;
      wait_idle("idle_q30", 1000);
      exp_q = '{1, 3, 2, 0, 1, 2, 3, 1};
      check_log("seq_q30");

      // quarter trigger arriving mid-hour-sequence is dropped
      log_q.delete();
      set_time(8'h04, 8'h59, 8'h59);
      cycles(3);
      set_time(8'h05, 8'h00, 8'h00);
      cycles(40);
      miss_cnt = 0;
      set_time(8'h05, 8'h14, 8'h59);
      cycles(2);
      set_time(8'h05, 8'h15, 8'h00);
      wait_idle("idle_overlap", 3000);
      check("overlap_missed_pulses", miss_cnt, 1);
      exp_q = '{1, 3, 2, 0, 1, 2, 3, 1, 3, 1, 2, 0, 0, 2, 3, 1, 4, 4, 4, 4, 4};
      check_log("seq_overlap");

      // randomized triggers, ticks and back-pressure
      tick_mode  = 1;
      ready_mode = 2;
      for (int i = 0; i < 30; i++) begin
         logic [7:0] h;
         logic [7:0] qm;
         h = rand_hh();
         case ($urandom_range(0, 3))
            0:       qm = 8'h00;
            1:       qm = 8'h15;
            2:       qm = 8'h30;
            default: qm = 8'h45;
         endcase
         set_time(h, 8'h10, 8'h59);
         set_time(h, qm, 8'h00);
         cycles($urandom_range(5, 300));
      end
      wait_idle("idle_random", 3000);

      // async reset in the middle of the 11 o'clock strikes
      tick_mode  = 0;
      ready_mode = 1;
      set_time(8'h10, 8'h59, 8'h59);
      cycles(3);
      set_time(8'h11, 8'h00, 8'h00);
      begin
         int k;
         k = 0;
         while (!(out_valid && out_code == 3'd4) && k < 2000) begin
            @(negedge clk);
            k++;
         end
         if (k >= 2000) timeout_fail("strike_wait");
      end
      @(posedge clk);
      #3;
      check("pre_rst_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", int'(out_valid), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_missed", int'(missed), 0);
      check("async_rst_code", int'(out_code), 0);
      cycles(3);
      #2 rst_n = 1'b1;
      log_q.delete();
      cycles(50);
      check("post_rst_no_xfer", log_q.size(), 0);
      check("post_rst_busy", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
